// File: rtl/spu_pkg.sv
// Shared SPU definitions for the odd-pipe local-store stage: opcodes, formats,
// local-store geometry and the load/store decoder.
package spu_pkg;

  typedef logic [0:127] quadword_t;

  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RRR  = 3'd1,
    FMT_RI7  = 3'd2,
    FMT_RI8  = 3'd3,
    FMT_RI10 = 3'd4,
    FMT_RI16 = 3'd5,
    FMT_RI18 = 3'd6
  } fmt_e;

  // Opcodes right-justified in 11 bits, upper bits zero.
  localparam logic [10:0] OP_LQD  = 11'h034;
  localparam logic [10:0] OP_LQX  = 11'h1C4;
  localparam logic [10:0] OP_LQA  = 11'h061;
  localparam logic [10:0] OP_LQR  = 11'h067;
  localparam logic [10:0] OP_STQD = 11'h024;
  localparam logic [10:0] OP_STQX = 11'h144;
  localparam logic [10:0] OP_STQA = 11'h041;
  localparam logic [10:0] OP_STQR = 11'h047;

  localparam logic [31:0] LSLR     = 32'h0000_7FF0;
  localparam int          LS_DEPTH = 2048;
  localparam int          LS_AW    = 11;

  typedef enum logic [1:0] {LS_NONE, LS_LOAD, LS_STORE} ls_kind_e;
  typedef enum logic [1:0] {AM_D, AM_X, AM_A, AM_R}     ls_mode_e;

  typedef struct packed {
    ls_kind_e kind;
    ls_mode_e mode;
  } ls_dec_t;

  // An opcode only counts when it arrives with its own instruction format.
  function automatic ls_dec_t ls_decode(input logic [10:0] op, input fmt_e fmt);
    ls_dec_t d;
    d.kind = LS_NONE;
    d.mode = AM_D;
    case (op)
      OP_LQD:  if (fmt == FMT_RI10) d = '{LS_LOAD,  AM_D};
      OP_LQX:  if (fmt == FMT_RR)   d = '{LS_LOAD,  AM_X};
      OP_LQA:  if (fmt == FMT_RI16) d = '{LS_LOAD,  AM_A};
      OP_LQR:  if (fmt == FMT_RI16) d = '{LS_LOAD,  AM_R};
      OP_STQD: if (fmt == FMT_RI10) d = '{LS_STORE, AM_D};
      OP_STQX: if (fmt == FMT_RR)   d = '{LS_STORE, AM_X};
      OP_STQA: if (fmt == FMT_RI16) d = '{LS_STORE, AM_A};
      OP_STQR: if (fmt == FMT_RI16) d = '{LS_STORE, AM_R};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ls_mem.sv
// 2048 x 128 local-store array: synchronous write, combinational read.
// LOCAL_STORE_CLEAR_ON_RESET_EN makes reset zero every entry.
module ls_mem import spu_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [LS_AW-1:0] addr,
  input  quadword_t        wdata,
  output quadword_t        rdata
);

  quadword_t mem [LS_DEPTH];

`ifdef LOCAL_STORE_CLEAR_ON_RESET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LS_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Contents survive reset, but no store may land while reset is held.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[addr] <= wdata;
  end
`endif

  assign rdata = mem[addr];

endmodule

// File: rtl/local_store.sv
// SPU odd-pipe local-store stage: quadword loads/stores against a 32 KB store,
// load results through a staging register then write-back. Option macro:
// LOCAL_STORE_CLEAR_ON_RESET_EN (clear memory on reset).
module local_store import spu_pkg::*; (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:10]  op_code,
  input  logic [2:0]   instr_format,
  input  logic [0:6]   dest_reg_addr,
  input  logic [0:127] src_reg_a,
  input  logic [0:127] src_reg_b,
  input  logic [0:127] store_reg,
  input  logic [0:17]  imm_value,
  input  logic         enable_reg_write,
  input  logic         branch_is_taken,
  output logic [0:127] wb_data,
  output logic [0:6]   wb_reg_addr,
  output logic         wb_enable_reg_write,
  output logic [0:6]   delayed_rt_addr,
  output logic         delayed_enable_reg_write
);

  localparam int STAGES = 2;

  ls_dec_t          dec;
  logic [31:0]      ra_w, rb_w, i10_sh, i16_sh, ea, lsa, pc;
  logic [LS_AW-1:0] idx;
  logic             ld_go, st_go;
  quadword_t        rdata, delayed_rt_data;
  logic [STAGES:1]  vld_pipe;

  always_comb begin
    dec    = ls_decode(op_code, fmt_e'(instr_format));
    ra_w   = src_reg_a[0:31];
    rb_w   = src_reg_b[0:31];
    i10_sh = {{18{imm_value[8]}}, imm_value[8:17], 4'b0000};
    i16_sh = {{14{imm_value[2]}}, imm_value[2:17], 2'b00};
    case (dec.mode)
      AM_D:    ea = ra_w + i10_sh;
      AM_X:    ea = ra_w + rb_w;
      AM_A:    ea = i16_sh;
      default: ea = pc + i16_sh;
    endcase
    lsa   = ea & LSLR;
    idx   = lsa[14:4];
    ld_go = (dec.kind == LS_LOAD)  && !branch_is_taken;
    st_go = (dec.kind == LS_STORE) && !branch_is_taken;
  end

  ls_mem u_mem (
    .clock (clock),
    .reset (reset),
    .we    (st_go),
    .addr  (idx),
    .wdata (store_reg),
    .rdata (rdata)
  );

  // Free-running instruction address for r-form; a flush does not hold it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= '0;
    else       pc <= pc + 32'd4;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delayed_rt_data <= '0;
      delayed_rt_addr <= '0;
      vld_pipe        <= '0;
      wb_data         <= '0;
      wb_reg_addr     <= '0;
    end else begin
      delayed_rt_data <= ld_go ? rdata : '0;
      delayed_rt_addr <= dest_reg_addr;
      vld_pipe        <= {vld_pipe[1], ld_go & enable_reg_write};
      wb_data         <= delayed_rt_data;
      wb_reg_addr     <= delayed_rt_addr;
    end
  end

  assign delayed_enable_reg_write = vld_pipe[1];
  assign wb_enable_reg_write      = vld_pipe[2];

  logic unused_bits;
  assign unused_bits = ^{src_reg_a[32:127], src_reg_b[32:127], imm_value[0:1],
                         lsa[31:15], lsa[3:0]};

endmodule

// File: tb/tb_local_store.sv
// Bench for local_store: vector table plus reset / r-form sequences, checked
// through an expected-result queue popped at write-back.
module tb_local_store;

  logic         clock = 1'b0;
  logic         reset;
  logic [0:10]  op_code;
  logic [2:0]   instr_format;
  logic [0:6]   dest_reg_addr;
  logic [0:127] src_reg_a, src_reg_b, store_reg;
  logic [0:17]  imm_value;
  logic         enable_reg_write, branch_is_taken;
  logic [0:127] wb_data;
  logic [0:6]   wb_reg_addr;
  logic         wb_enable_reg_write;
  logic [0:6]   delayed_rt_addr;
  logic         delayed_enable_reg_write;

  local_store dut (
    .clock(clock), .reset(reset), .op_code(op_code), .instr_format(instr_format),
    .dest_reg_addr(dest_reg_addr), .src_reg_a(src_reg_a), .src_reg_b(src_reg_b),
    .store_reg(store_reg), .imm_value(imm_value), .enable_reg_write(enable_reg_write),
    .branch_is_taken(branch_is_taken), .wb_data(wb_data), .wb_reg_addr(wb_reg_addr),
    .wb_enable_reg_write(wb_enable_reg_write), .delayed_rt_addr(delayed_rt_addr),
    .delayed_enable_reg_write(delayed_enable_reg_write)
  );

  always #5 clock = ~clock;

  localparam logic [10:0] LQD = 11'h034, LQX = 11'h1C4, LQA = 11'h061, LQR = 11'h067;
  localparam logic [10:0] STQD = 11'h024, STQX = 11'h144, STQA = 11'h041, STQR = 11'h047;
  localparam logic [2:0]  RR = 3'd0, RI10 = 3'd4, RI16 = 3'd5;
  localparam logic [95:0] FILL = 96'hF00D_BEEF_C0DE_5A5A_A5A5_1234;
  localparam logic [127:0] Q1 = 128'h1F34BE0A6D8C92F7B5A19E1A1F34BE0A;
  localparam logic [127:0] Q2 = 128'hCA3D19E84B26F7A0D5A8C1B7CA3D19E8;
  localparam logic [127:0] Q3 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] Q4 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] Q5 = 128'h76543210FEDCBA9889ABCDEF01234567;

  typedef struct {
    logic [10:0]  op;
    logic [2:0]   fmt;
    logic [6:0]   dest;
    logic [31:0]  ra, rb;
    logic [127:0] st;
    logic [17:0]  imm;
    logic         en, br;
    logic [127:0] xd;
    logic         xe;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [6:0]   a;
    logic         e;
    string        tag;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0, nbad = 0;
  logic [31:0] pc_m;

  function automatic vec_t mk(input logic [10:0] op, input logic [2:0] fmt,
                              input logic [6:0] dest, input logic [31:0] ra,
                              input logic [31:0] rb, input logic [127:0] st,
                              input logic [17:0] imm, input logic en, input logic br,
                              input logic [127:0] xd, input logic xe);
    vec_t v;
    v.op = op; v.fmt = fmt; v.dest = dest; v.ra = ra; v.rb = rb; v.st = st;
    v.imm = imm; v.en = en; v.br = br; v.xd = xd; v.xe = xe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic restart_sb();
    exp_t z;
    z.d = '0; z.a = '0; z.e = 1'b0; z.tag = "reset";
    q.delete();
    q.push_back(z);
    pc_m = '0;
  endtask

  // One instruction per cycle: drive, queue its staging result, then check
  // the staging outputs for it and write-back for the previous one.
  task automatic issue(input vec_t v, input string tag);
    exp_t e, n;
    @(negedge clock);
    op_code = v.op; instr_format = v.fmt; dest_reg_addr = v.dest;
    src_reg_a = {v.ra, FILL}; src_reg_b = {v.rb, ~FILL}; store_reg = v.st;
    imm_value = v.imm; enable_reg_write = v.en; branch_is_taken = v.br;
    n.d = v.xd; n.a = v.dest; n.e = v.xe; n.tag = tag;
    q.push_back(n);
    @(posedge clock); #1;
    pc_m += 32'd4;
    if (q.size() < 2) begin
      nchk++; nbad++;
      $display("FAIL %s scoreboard act=%0d exp=2", tag, q.size());
    end else begin
      e = q.pop_front();
      chk({e.tag, " wb_data"}, wb_data, e.d);
      chk({e.tag, " wb_reg_addr"}, 128'(wb_reg_addr), 128'(e.a));
      chk({e.tag, " wb_en"}, 128'(wb_enable_reg_write), 128'(e.e));
    end
    chk({tag, " dly_addr"}, 128'(delayed_rt_addr), 128'(q[0].a));
    chk({tag, " dly_en"}, 128'(delayed_enable_reg_write), 128'(q[0].e));
  endtask

  task automatic nop(input string tag);
    issue(mk(11'h0, RR, 7'd0, 32'h0, 32'h0, '0, '0, 1'b0, 1'b0, '0, 1'b0), tag);
  endtask

  vec_t        v[16];
  logic [31:0] a_st, diff;

  initial begin
    v[0]  = mk(11'h0, RR,   7'd5,   32'h100,      32'h0,      Q4, 18'd0,     1, 0, '0, 0);
    v[1]  = mk(STQD,  RI10, 7'd7,   32'h100,      32'h0,      Q1, 18'd2,     1, 0, '0, 0);
    v[2]  = mk(LQD,   RI10, 7'd3,   32'h100,      32'h0,      '0, 18'd2,     1, 0, Q1, 1);
    v[3]  = mk(STQX,  RR,   7'd1,   32'h7DC680A1, 32'h9C86514E, Q2, 18'd0,   1, 0, '0, 0);
    v[4]  = mk(LQX,   RR,   7'd10,  32'h7DC680A1, 32'h9C86514E, '0, 18'd0,   1, 0, Q2, 1);
    v[5]  = mk(STQA,  RI16, 7'd0,   32'h0,        32'h0,      Q3, 18'h0FFFF, 1, 0, '0, 0);
    v[6]  = mk(LQA,   RI16, 7'd127, 32'h0,        32'h0,      '0, 18'h01FFF, 1, 0, Q3, 1);
    v[7]  = mk(LQD,   RI10, 7'd4,   32'h100,      32'h0,      '0, 18'd2,     1, 1, '0, 0);
    v[8]  = mk(STQD,  RI10, 7'd4,   32'h100,      32'h0,      Q4, 18'd2,     1, 1, '0, 0);
    v[9]  = mk(LQD,   RI10, 7'd4,   32'h100,      32'h0,      '0, 18'd2,     1, 0, Q1, 1);
    v[10] = mk(11'h0, RR,   7'd8,   32'h120,      32'h0,      Q4, 18'd0,     1, 0, '0, 0);
    v[11] = mk(LQD,   RI10, 7'd9,   32'h120,      32'h0,      '0, 18'd0,     1, 0, Q1, 1);
    v[12] = mk(LQD,   RI10, 7'd6,   32'h120,      32'h0,      '0, 18'd0,     0, 0, Q1, 0);
    v[13] = mk(LQD,   RR,   7'd11,  32'h120,      32'h0,      '0, 18'd0,     1, 0, '0, 0);
    v[14] = mk(LQD,   RI10, 7'd12,  32'h130,      32'h0,      '0, 18'h003FF, 1, 0, Q1, 1);
    v[15] = mk(LQD,   RI10, 7'd13,  32'h8120,     32'h0,      '0, 18'd0,     1, 0, Q1, 1);

    // Reset held with an adversarial store on the inputs.
    reset = 1'b1;
    op_code = STQD; instr_format = RI10; dest_reg_addr = 7'($urandom);
    src_reg_a = {$urandom, $urandom, $urandom, $urandom};
    src_reg_b = {$urandom, $urandom, $urandom, $urandom};
    store_reg = {$urandom, $urandom, $urandom, $urandom};
    imm_value = 18'($urandom); enable_reg_write = 1'b1; branch_is_taken = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst wb_data", wb_data, '0);
    chk("rst wb_reg_addr", 128'(wb_reg_addr), '0);
    chk("rst wb_en", 128'(wb_enable_reg_write), '0);
    chk("rst dly_addr", 128'(delayed_rt_addr), '0);
    chk("rst dly_en", 128'(delayed_enable_reg_write), '0);
    reset = 1'b0;
    restart_sb();

    nop("first_nop");
    for (int i = 0; i < 16; i++) issue(v[i], $sformatf("vec%0d", i));
    nop("drain0");

    // Reset in the middle of a load discards it at once.
    issue(mk(LQD, RI10, 7'd2, 32'h100, 32'h0, '0, 18'd2, 1, 0, Q1, 1), "ld_pre_rst");
    #2 reset = 1'b1;
    #1;
    chk("midrst dly_en", 128'(delayed_enable_reg_write), '0);
    chk("midrst dly_addr", 128'(delayed_rt_addr), '0);
    chk("midrst wb_en", 128'(wb_enable_reg_write), '0);
    chk("midrst wb_data", wb_data, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    restart_sb();
    nop("post_rst0");
    nop("post_rst1");

    // r-form: store at the current PC, read it back absolutely and relatively.
    a_st = pc_m;
    issue(mk(STQR, RI16, 7'd0, 32'h0, 32'h0, Q5, 18'd0, 1, 0, '0, 0), "stqr");
    issue(mk(LQA, RI16, 7'd20, 32'h0, 32'h0, '0, {2'b00, 16'((a_st & 32'h7FF0) >> 2)},
             1, 0, Q5, 1), "lqa_pc");
    nop("gap0");
    nop("gap1");
    diff = a_st - pc_m;
    issue(mk(LQR, RI16, 7'd21, 32'h0, 32'h0, '0, {2'b00, diff[17:2]}, 1, 0, Q5, 1), "lqr");
    nop("drain1");

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
